// File: rtl/q50_count_checker.sv
// q50_count_checker
// Receive-side monitor for the Q50 3-bit mod-7 count streams. Checks each
// valid sample against the expected successor in the selected sequence
// (binary 0..6 or skip 0,1,2,4,6), tracks lock, flags and counts sequence
// errors, and decodes legal samples into their sequence position.
module q50_count_checker #(
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode,
  input  logic             valid,
  input  logic [2:0]       count_in,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       index,
  output logic             index_valid
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [2:0]       LOCK_TARGET = 3'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  logic [1:0]       state_reg, state_next;
  logic [2:0]       prev_reg, prev_next;
  logic [2:0]       run_reg, run_next;
  logic             mode_q_reg, mode_q_next;
  logic             err_reg, err_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic [2:0]       index_reg, index_next;
  logic             index_valid_reg, index_valid_next;

  logic [7:0] legal_mask;
  logic       legal;
  logic [2:0] succ;
  logic [2:0] idx_dec;
  logic       is_succ;
  logic       mode_change;
  logic [2:0] run_inc;

  // Per-value legality for the currently selected sequence
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_legal
      localparam bit IN_BIN  = (gi < 7);
      localparam bit IN_SKIP = (gi == 0) || (gi == 1) || (gi == 2) ||
                               (gi == 4) || (gi == 6);
      assign legal_mask[gi] = mode ? IN_SKIP : IN_BIN;
    end
  endgenerate

  assign legal       = legal_mask[count_in];
  assign is_succ     = legal && (count_in == succ);
  assign mode_change = (mode != mode_q_reg);
  assign run_inc     = run_reg + 3'd1;

  // Expected successor of the stored previous value
  always_comb begin
    succ = 3'd0;
    if (!mode) begin
      succ = (prev_reg == 3'd6) ? 3'd0 : prev_reg + 3'd1;
    end else begin
      case (prev_reg)
        3'd0:    succ = 3'd1;
        3'd1:    succ = 3'd2;
        3'd2:    succ = 3'd4;
        3'd4:    succ = 3'd6;
        default: succ = 3'd0;
      endcase
    end
  end

  // Sequence-position decode of the current sample; illegal samples give 0
  always_comb begin
    idx_dec = 3'd0;
    if (legal) begin
      if (!mode) begin
        idx_dec = count_in;
      end else begin
        case (count_in)
          3'd4:    idx_dec = 3'd3;
          3'd6:    idx_dec = 3'd4;
          default: idx_dec = count_in;
        endcase
      end
    end
  end

  // Lock tracking, error detection and saturating error count
  always_comb begin
    state_next       = state_reg;
    prev_next        = prev_reg;
    run_next         = run_reg;
    mode_q_next      = mode_q_reg;
    err_next         = 1'b0;
    err_cnt_next     = err_cnt_reg;
    index_next       = index_reg;
    index_valid_next = index_valid_reg;

    if (valid) begin
      index_next       = idx_dec;
      index_valid_next = legal;

      if (mode_change) begin
        // A mode switch restarts acquisition from this sample, silently
        mode_q_next = mode;
        if (legal) begin
          prev_next  = count_in;
          run_next   = 3'd0;
          state_next = ST_ACQUIRE;
        end else begin
          state_next = ST_IDLE;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (legal) begin
              prev_next  = count_in;
              run_next   = 3'd0;
              state_next = ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (is_succ) begin
              prev_next = count_in;
              run_next  = run_inc;
              if (run_inc == LOCK_TARGET) begin
                state_next = ST_LOCKED;
              end
            end else if (legal) begin
              prev_next = count_in;
              run_next  = 3'd0;
            end else begin
              state_next = ST_IDLE;
            end
          end
          ST_LOCKED: begin
            if (is_succ) begin
              prev_next = count_in;
            end else begin
              err_next = 1'b1;
              if (legal) begin
                prev_next  = count_in;
                run_next   = 3'd0;
                state_next = ST_ACQUIRE;
              end else begin
                state_next = ST_IDLE;
              end
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end

    if (err_next && (err_cnt_reg != ERR_MAX)) begin
      err_cnt_next = err_cnt_reg + ERR_W'(1);
    end
    // Clear wins over a same-cycle increment
    if (clear) begin
      err_cnt_next = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= ST_IDLE;
      prev_reg        <= 3'd0;
      run_reg         <= 3'd0;
      mode_q_reg      <= 1'b0;
      err_reg         <= 1'b0;
      err_cnt_reg     <= '0;
      index_reg       <= 3'd0;
      index_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= prev_next;
      run_reg         <= run_next;
      mode_q_reg      <= mode_q_next;
      err_reg         <= err_next;
      err_cnt_reg     <= err_cnt_next;
      index_reg       <= index_next;
      index_valid_reg <= index_valid_next;
    end
  end

  assign locked      = (state_reg == ST_LOCKED);
  assign err         = err_reg;
  assign err_cnt     = err_cnt_reg;
  assign index       = index_reg;
  assign index_valid = index_valid_reg;

endmodule

// File: tb/tb_q50_count_checker.sv
// Testbench for q50_count_checker: directed scenarios plus randomized
// traffic, all checked against a sequence-table reference model.
module tb_q50_count_checker;

  localparam int ERR_W   = 8;
  localparam int LOCK_N  = 3;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             rstn;
  logic             mode;
  logic             valid;
  logic [2:0]       count_in;
  logic             clear;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [2:0]       index;
  logic             index_valid;

  int n_tests = 0;
  int n_fail  = 0;

  q50_count_checker #(.ERR_W(ERR_W), .LOCK_N(LOCK_N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mode       (mode),
    .valid      (valid),
    .count_in   (count_in),
    .clear      (clear),
    .locked     (locked),
    .err        (err),
    .err_cnt    (err_cnt),
    .index      (index),
    .index_valid(index_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ERR_W+5:0] obs;
  assign obs = {locked, err, err_cnt, index, index_valid};

  // ---------------- reference model ----------------
  int skip_seq [5] = '{0, 1, 2, 4, 6};

  int          m_phase;   // 0 idle, 1 acquiring, 2 locked
  int          m_prev;
  int          m_run;
  bit          m_mode;
  int          m_err_cnt;
  int          m_index;
  bit          m_iv;
  bit          m_err;
  logic [ERR_W+5:0] exp_out;

  // position of v in the selected sequence, -1 when not a member
  function automatic int pos_of(bit md, int v);
    if (!md) return (v >= 0 && v <= 6) ? v : -1;
    for (int i = 0; i < 5; i++) if (skip_seq[i] == v) return i;
    return -1;
  endfunction

  function automatic int succ_of(bit md, int v);
    int p, np;
    p  = pos_of(md, v);
    if (p < 0) p = 0;
    np = (p + 1) % (md ? 5 : 7);
    return md ? skip_seq[np] : np;
  endfunction

  function automatic void pack_exp();
    exp_out = {(m_phase == 2), m_err, ERR_W'(m_err_cnt), 3'(m_index), m_iv};
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_prev = 0; m_run = 0; m_mode = 0;
    m_err_cnt = 0; m_index = 0; m_iv = 0; m_err = 0;
    pack_exp();
  endfunction

  function automatic void model_step(bit v, bit md, int cin, bit clr);
    int p;
    bool_block: begin
      m_err = 0;
      if (v) begin
        p       = pos_of(md, cin);
        m_index = (p < 0) ? 0 : p;
        m_iv    = (p >= 0);
        if (md != m_mode) begin
          m_mode = md;
          if (p >= 0) begin m_phase = 1; m_prev = cin; m_run = 0; end
          else m_phase = 0;
        end else if (m_phase == 0) begin
          if (p >= 0) begin m_phase = 1; m_prev = cin; m_run = 0; end
        end else if (m_phase == 1) begin
          if (p >= 0 && cin == succ_of(md, m_prev)) begin
            m_prev = cin;
            m_run++;
            if (m_run == LOCK_N) m_phase = 2;
          end else if (p >= 0) begin
            m_prev = cin; m_run = 0;
          end else m_phase = 0;
        end else begin
          if (p >= 0 && cin == succ_of(md, m_prev)) begin
            m_prev = cin;
          end else begin
            m_err = 1;
            if (m_err_cnt < ERR_MAX) m_err_cnt++;
            if (p >= 0) begin m_phase = 1; m_prev = cin; m_run = 0; end
            else m_phase = 0;
          end
        end
      end
      if (clr) m_err_cnt = 0;
    end
    pack_exp();
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic cycle(input bit v, input bit md, input int cin, input bit clr);
    valid    = v;
    mode     = md;
    count_in = 3'(cin);
    clear    = clr;
    model_step(v, md, cin, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; valid = 1'b0; clear = 1'b0; count_in = 3'd0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic feed_until_locked(input bit md);
    for (int i = 0; i < 12 && m_phase != 2; i++) begin
      cycle(1, md, (m_phase == 0 || md != m_mode) ? 0 : succ_of(md, m_prev), 0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; mode = 1'b0; valid = 1'b0; count_in = 3'd0; clear = 1'b0;
    model_reset();
    #3;
    n_tests++;
    if (obs !== '0) begin
      $display("FAIL reset_outputs got=%h want=0", obs); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n_tests++;
    if (obs !== exp_out) begin
      $display("FAIL reset_release got=%h want=%h", obs, exp_out); n_fail++;
    end
  endtask

  task automatic test_bin_lock();
    int stream [9] = '{0, 1, 2, 3, 4, 5, 6, 0, 1};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, stream[i], 0);
      n_tests++;
      if (obs !== exp_out) begin
        $display("FAIL bin_lock[%0d] in=%0d got=%h want=%h", i, stream[i], obs, exp_out); n_fail++;
      end
      n_tests++;
      if (locked !== (i >= 3) || index !== 3'(stream[i]) || err !== 1'b0) begin
        $display("FAIL bin_lock_direct[%0d] locked=%b index=%0d err=%b want locked=%b index=%0d err=0",
                 i, locked, index, err, (i >= 3), stream[i]); n_fail++;
      end
    end
  endtask

  task automatic test_skip_lock();
    int stream [7] = '{0, 1, 2, 4, 6, 0, 1};
    int idx    [7] = '{0, 1, 2, 3, 4, 0, 1};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1, 1, stream[i], 0);
      n_tests++;
      if (obs !== exp_out || index !== 3'(idx[i]) || index_valid !== 1'b1 ||
          locked !== (i >= 3)) begin
        $display("FAIL skip_lock[%0d] got=%h want=%h index=%0d want_index=%0d", i, obs, exp_out,
                 index, idx[i]); n_fail++;
      end
    end
  endtask

  task automatic test_err_acquire();
    int pre  [4] = '{6, 0, 1, 2};
    int post [3] = '{6, 0, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, pre[i], 0);
    n_tests++;
    if (locked !== 1'b1) begin
      $display("FAIL err_acq_prelock got=%b want=1", locked); n_fail++;
    end
    cycle(1, 0, 5, 0);
    n_tests++;
    if (obs !== exp_out || err !== 1'b1 || err_cnt !== ERR_W'(1) || locked !== 1'b0) begin
      $display("FAIL err_acq_inject got=%h want=%h", obs, exp_out); n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, post[i], 0);
      n_tests++;
      if (obs !== exp_out || err !== 1'b0 || locked !== (i == 2)) begin
        $display("FAIL err_acq_relock[%0d] got=%h want=%h", i, obs, exp_out); n_fail++;
      end
    end
  endtask

  task automatic test_illegal_locked();
    apply_reset();
    feed_until_locked(1);
    cycle(1, 1, 3, 0);
    n_tests++;
    if (obs !== exp_out || err !== 1'b1 || index_valid !== 1'b0 || index !== 3'd0 ||
        locked !== 1'b0) begin
      $display("FAIL illegal_locked got=%h want=%h", obs, exp_out); n_fail++;
    end
    cycle(1, 1, 0, 0);
    n_tests++;
    if (obs !== exp_out || err !== 1'b0 || index_valid !== 1'b1 || m_phase != 1) begin
      $display("FAIL illegal_reseed got=%h want=%h", obs, exp_out); n_fail++;
    end
    for (int i = 0; i < 3; i++) cycle(1, 1, succ_of(1, m_prev), 0);
    n_tests++;
    if (locked !== 1'b1 || obs !== exp_out) begin
      $display("FAIL illegal_relock got=%h want=%h", obs, exp_out); n_fail++;
    end
  endtask

  task automatic test_saturate();
    int wrong;
    apply_reset();
    for (int e = 0; e < ERR_MAX + 3; e++) begin
      feed_until_locked(0);
      wrong = (succ_of(0, m_prev) + 1) % 7;
      cycle(1, 0, wrong, 0);
      n_tests++;
      if (obs !== exp_out) begin
        $display("FAIL saturate[%0d] got=%h want=%h", e, obs, exp_out); n_fail++;
      end
    end
    n_tests++;
    if (err_cnt !== ERR_W'(ERR_MAX)) begin
      $display("FAIL saturate_final got=%0d want=%0d", err_cnt, ERR_MAX); n_fail++;
    end
    feed_until_locked(0);
    wrong = (succ_of(0, m_prev) + 3) % 7;
    cycle(1, 0, wrong, 1);
    n_tests++;
    if (err !== 1'b1 || err_cnt !== '0 || obs !== exp_out) begin
      $display("FAIL clear_on_err err=%b err_cnt=%0d want err=1 err_cnt=0", err, err_cnt); n_fail++;
    end
    cycle(0, 0, 0, 0);
    n_tests++;
    if (err !== 1'b0 || obs !== exp_out) begin
      $display("FAIL idle_no_err got=%h want=%h", obs, exp_out); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    feed_until_locked(0);
    cycle(1, 0, succ_of(0, m_prev) + 2 > 6 ? 0 : (succ_of(0, m_prev) + 2), 0); // error: count 1
    feed_until_locked(0);
    n_tests++;
    if (locked !== 1'b1 || err_cnt !== ERR_W'(1)) begin
      $display("FAIL async_prelock locked=%b err_cnt=%0d want 1/1", locked, err_cnt); n_fail++;
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (obs !== '0) begin
      $display("FAIL async_reset_drop got=%h want=0", obs); n_fail++;
    end
    model_reset();
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, i, 0);
      n_tests++;
      if (obs !== exp_out || locked !== (i == 3)) begin
        $display("FAIL async_relock[%0d] got=%h want=%h", i, obs, exp_out); n_fail++;
      end
    end
  endtask

  task automatic test_mode_toggle();
    int s1 [3] = '{1, 2, 4};
    apply_reset();
    feed_until_locked(0);
    cycle(1, 1, 0, 0);
    n_tests++;
    if (obs !== exp_out || err !== 1'b0 || locked !== 1'b0 || err_cnt !== '0) begin
      $display("FAIL mode_toggle got=%h want=%h", obs, exp_out); n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, s1[i], 0);
      n_tests++;
      if (obs !== exp_out || locked !== (i == 2)) begin
        $display("FAIL mode_reacquire[%0d] got=%h want=%h", i, obs, exp_out); n_fail++;
      end
    end
  endtask

  task automatic test_random();
    bit r_mode = 0;
    bit v, clr;
    int cin;
    int shown = 0;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) r_mode = ~r_mode;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if (m_phase != 0 && r_mode == m_mode && $urandom_range(0, 9) < 8)
        cin = succ_of(r_mode, m_prev);
      else
        cin = $urandom_range(0, 7);
      cycle(v, r_mode, cin, clr);
      n_tests++;
      if (obs !== exp_out) begin
        n_fail++;
        if (shown < 20) begin
          $display("FAIL random[%0d] v=%b md=%b in=%0d clr=%b got=%h want=%h",
                   i, v, r_mode, cin, clr, obs, exp_out);
          shown++;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bin_lock();
    test_skip_lock();
    test_err_acquire();
    test_illegal_locked();
    test_saturate();
    test_async_reset();
    test_mode_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
